// File: rtl/etc_lane_arbiter.sv
// Round-robin arbiter sharing one ETC speed-measurement engine between two lanes.
// Optional timeout/abort logic is enabled by defining ETC_ARB_TIMEOUT_EN.
module etc_lane_arbiter #(
    parameter int WIDTH_SPEED = 14,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             req,
    input  logic                   eng_done,
    input  logic [WIDTH_SPEED-1:0] eng_speed,
    output logic [1:0]             grant,
    output logic                   eng_start,
    output logic                   eng_abort,
    output logic                   res_valid,
    output logic                   res_lane,
    output logic [WIDTH_SPEED-1:0] res_speed,
    output logic                   res_timeout,
    output logic                   busy
);

    // state     | meaning
    // S_IDLE    | engine free, waiting for a lane request
    // S_GRANT   | one cycle: grant asserted, engine start pulsed
    // S_BUSY    | engine measuring, waiting for done (or timeout)
    // S_RELEASE | one cycle: result strobed, grant still held
    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_BUSY,
        S_RELEASE
    } state_t;

    state_t state;
    logic   lane;
    logic   last_served;
    logic   sel_lane;

    // On a tie the lane that was not served last wins.
    always_comb begin
        sel_lane = 1'b0;
        if (req == 2'b11)
            sel_lane = ~last_served;
        else
            sel_lane = req[1];
    end

`ifdef ETC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            lane        <= 1'b0;
            last_served <= 1'b1;
            grant       <= 2'b00;
            eng_start   <= 1'b0;
            eng_abort   <= 1'b0;
            res_valid   <= 1'b0;
            res_lane    <= 1'b0;
            res_speed   <= '0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
`ifdef ETC_ARB_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            eng_start   <= 1'b0;
            eng_abort   <= 1'b0;
            res_valid   <= 1'b0;
            res_lane    <= 1'b0;
            res_speed   <= '0;
            res_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state     <= S_GRANT;
                        lane      <= sel_lane;
                        grant     <= sel_lane ? 2'b10 : 2'b01;
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_GRANT: begin
                    state <= S_BUSY;
`ifdef ETC_ARB_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                S_BUSY: begin
                    // Done takes priority over a coincident timeout.
                    if (eng_done) begin
                        state       <= S_RELEASE;
                        res_valid   <= 1'b1;
                        res_lane    <= lane;
                        res_speed   <= eng_speed;
                        res_timeout <= 1'b0;
                    end
`ifdef ETC_ARB_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state       <= S_RELEASE;
                        res_valid   <= 1'b1;
                        res_lane    <= lane;
                        res_speed   <= '0;
                        res_timeout <= 1'b1;
                        eng_abort   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                S_RELEASE: begin
                    state       <= S_IDLE;
                    last_served <= lane;
                    grant       <= 2'b00;
                    busy        <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    grant <= 2'b00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_etc_lane_arbiter.sv
// Self-checking bench for etc_lane_arbiter: transaction-timeline model plus directed checks.
module tb_etc_lane_arbiter;

    localparam int W  = 14;
    localparam int TO = 16;
`ifdef ETC_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   req = 2'b00;
    logic         eng_done = 1'b0;
    logic [W-1:0] eng_speed = '0;
    logic [1:0]   grant;
    logic         eng_start, eng_abort, res_valid, res_lane, res_timeout, busy;
    logic [W-1:0] res_speed;

    int checks = 0;
    int errors = 0;

    etc_lane_arbiter #(.WIDTH_SPEED(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .eng_done(eng_done),
        .eng_speed(eng_speed), .grant(grant), .eng_start(eng_start),
        .eng_abort(eng_abort), .res_valid(res_valid), .res_lane(res_lane),
        .res_speed(res_speed), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: each transaction is a grant cycle g and a release cycle r; the
    // lane is granted over [g, r], and the engine is free again after r.
    int           cyc = 0;
    bit           m_active = 1'b0;
    bit           m_lane = 1'b0;
    bit           m_last = 1'b1;
    int           m_g = 0;
    int           m_r = -1;
    logic [W-1:0] m_speed = '0;
    bit           m_to = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_last   = 1'b1;
            m_r      = -1;
            m_to     = 1'b0;
            m_speed  = '0;
        end else begin
            cyc = cyc + 1;
            if (m_active && m_r >= 0 && cyc == m_r + 1) begin
                m_active = 1'b0;
                m_last   = m_lane;
            end else if (!m_active) begin
                if (req != 2'b00) begin
                    m_active = 1'b1;
                    m_lane   = (req == 2'b11) ? !m_last : req[1];
                    m_g      = cyc;
                    m_r      = -1;
                end
            end else if (m_r < 0 && cyc - 1 > m_g) begin
                if (eng_done) begin
                    m_r = cyc; m_speed = eng_speed; m_to = 1'b0;
                end else if (TO_EN && (cyc - 1 - m_g) == TO) begin
                    m_r = cyc; m_speed = '0; m_to = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic         e_valid;
        logic [21:0]  exp_v, act_v;
        e_valid = m_active && (m_r >= 0) && (cyc == m_r);
        exp_v = {m_active ? (m_lane ? 2'b10 : 2'b01) : 2'b00,
                 m_active && (cyc == m_g),
                 e_valid && m_to,
                 e_valid,
                 e_valid ? m_lane : 1'b0,
                 e_valid ? m_speed : {W{1'b0}},
                 e_valid ? m_to : 1'b0,
                 m_active};
        act_v = {grant, eng_start, eng_abort, res_valid,
                 res_valid ? res_lane : 1'b0,
                 res_valid ? res_speed : {W{1'b0}},
                 res_valid ? res_timeout : 1'b0,
                 busy};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_compare cyc=%0d actual=%h required=%h", cyc, act_v, exp_v);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!eng_start && n < 12) begin
            step(1);
            n++;
        end
        chk(name, {31'd0, eng_start}, 32'd1);
    endtask

    task automatic run_txn(input logic [1:0] r, input int dly, input logic [W-1:0] spd,
                           input bit hold, output logic [1:0] g);
        req = r;
        wait_start("start_seen");
        g = grant;
        if (!hold) req = 2'b00;
        step(dly);
        eng_done  = 1'b1;
        eng_speed = spd;
        step(1);
        eng_done  = 1'b0;
        eng_speed = '0;
        chk("res_valid", {31'd0, res_valid}, 32'd1);
        chk("res_speed", {18'd0, res_speed}, {18'd0, spd});
        chk("res_timeout", {31'd0, res_timeout}, 32'd0);
    endtask

    logic [1:0] g;
    logic [1:0] rr_exp [4];
    int         cnt;
    bit         seen;

    initial begin
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

        reset_n = 1'b0;
        req     = 2'b11;
        step(3);
        chk("reset_outputs", {10'd0, grant, eng_start, eng_abort, res_valid, res_lane,
                              res_speed, res_timeout, busy}, 32'd0);
        reset_n = 1'b1;
        step(1);
        chk("first_grant", {30'd0, grant}, 32'd1);
        chk("first_start", {31'd0, eng_start}, 32'd1);
        run_txn(2'b11, 3, 14'd5, 1'b0, g);
        chk("first_lane", {30'd0, g}, 32'd1);
        step(1);

        run_txn(2'b10, 5, 14'd60, 1'b0, g);
        chk("single_res_lane", {31'd0, res_lane}, 32'd1);
        chk("single_grant_held", {30'd0, grant}, 32'd2);
        step(1);
        chk("single_released", {30'd0, grant, busy}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            run_txn(2'b11, 2, W'(100 + i), 1'b1, g);
            chk("rr_grant", {30'd0, g}, {30'd0, rr_exp[i]});
        end
        req = 2'b00;
        step(2);

        req = 2'b01;
        wait_start("to_start");
        req = 2'b00;
        step(1);
        cnt = 0;
        while (busy && !res_valid && cnt < 100) begin
            cnt++;
            step(1);
        end
`ifdef ETC_ARB_TIMEOUT_EN
        chk("to_busy_cycles", cnt, 32'd16);
        chk("to_valid", {31'd0, res_valid}, 32'd1);
        chk("to_flag", {31'd0, res_timeout}, 32'd1);
        chk("to_speed", {18'd0, res_speed}, 32'd0);
        chk("to_abort", {31'd0, eng_abort}, 32'd1);
        step(1);
`else
        chk("noto_busy_cycles", cnt, 32'd100);
        chk("noto_busy", {31'd0, busy}, 32'd1);
        chk("noto_no_valid", {31'd0, res_valid}, 32'd0);
        eng_done = 1'b1;
        step(1);
        eng_done = 1'b0;
        chk("noto_done_valid", {31'd0, res_valid}, 32'd1);
        chk("noto_abort", {31'd0, eng_abort}, 32'd0);
        step(1);
`endif
        step(1);

        run_txn(2'b01, 16, 14'd99, 1'b0, g);
        chk("edge_lane", {30'd0, g}, 32'd1);
        step(2);

        eng_done  = 1'b1;
        eng_speed = 14'd7;
        step(1);
        eng_done  = 1'b0;
        eng_speed = '0;
        seen = 1'b0;
        repeat (4) begin
            if (res_valid || busy) seen = 1'b1;
            step(1);
        end
        chk("idle_done_ignored", {31'd0, seen}, 32'd0);

        req = 2'b10;
        wait_start("mid_start");
        step(2);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_async", {29'd0, grant, busy}, 32'd0);
        req = 2'b11;
        step(2);
        reset_n = 1'b1;
        step(1);
        chk("post_reset_grant", {30'd0, grant}, 32'd1);
        req = 2'b00;
        step(2);
        eng_done = 1'b1;
        step(1);
        eng_done = 1'b0;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/etc_lane_arbiter.md
# etc_lane_arbiter

Round-robin arbiter that shares one non-stop ETC speed-measurement engine between two toll lanes. It watches per-lane vehicle requests, grants the engine to one lane at a time, and pulses the engine start. It then waits for the engine's completion, or aborts on timeout, and returns the measured speed tagged with the lane number. It sits between the two lanes' entry sensors and the single shared engine instance.

## Interface
- WIDTH_SPEED, 14, width of engine speed result and res_speed
- TIMEOUT_CYC, 1000000, max BUSY cycles before abort (>= 2)
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  2  per-lane level request (vehicle at lane entry), bit i = lane i
- eng_done  input  1  engine completion strobe, 1 cycle
- eng_speed  input  WIDTH_SPEED  engine result, valid when eng_done=1
- grant  output  2  one-hot lane grant, 0 when idle
- eng_start  output  1  1-cycle start pulse to engine
- eng_abort  output  1  1-cycle abort pulse to engine (timeout only)
- res_valid  output  1  1-cycle result strobe
- res_lane  output  1  lane index of result
- res_speed  output  WIDTH_SPEED  measured speed; 0 on timeout
- res_timeout  output  1  result was a timeout, qualified by res_valid
- busy  output  1  state != IDLE

## Operation
- FSM states: IDLE, GRANT, BUSY, RELEASE. Reset state is IDLE.
- IDLE: if any req bit is set, go to GRANT and latch the selected lane. If both bits are set, pick the lane != last_served. last_served resets to 1, so lane 0 wins the first tie.
- GRANT: one cycle. grant[lane]=1 and eng_start=1. Go to BUSY, clear timeout counter.
- BUSY: grant held. On eng_done=1: latch eng_speed, go to RELEASE with timeout flag 0. Otherwise increment counter. At counter == TIMEOUT_CYC-1 with no done, go to RELEASE with timeout flag 1.
- RELEASE: one cycle. grant held, res_valid=1, res_lane=lane, res_speed = latched value (0 if timeout), res_timeout = flag. eng_abort=1 only if timeout. last_served <= lane. Go to IDLE.
- eng_done sampled only in BUSY; ignored in IDLE/GRANT/RELEASE.
- Done and timeout in the same cycle: done wins, res_timeout=0.
- req deasserting while granted: ignored, the transaction completes normally.
- Counter width $clog2(TIMEOUT_CYC+1), saturating is not needed (it is cleared in GRANT).
- Reset, asynchronous and mid-operation: state IDLE immediately. All outputs 0, last_served=1, counter 0, latched speed 0.

## Timing
- Reset values: grant=0, eng_start=0, eng_abort=0, res_valid=0, res_lane=0, res_speed=0, res_timeout=0, busy=0.
- All outputs are registered or decoded from registered state, with no combinational path from inputs.
- req high at cycle T in IDLE: GRANT (grant, eng_start) at T+1, BUSY from T+2.
- eng_done at BUSY cycle D: RELEASE (res_valid) at D+1, IDLE at D+2. A new grant is possible at D+3 at the earliest.
- Timeout: BUSY occupies exactly TIMEOUT_CYC cycles, then RELEASE with eng_abort.
- Back-to-back: with req held continuously, lanes alternate each transaction.

## Configuration
- ETC_ARB_TIMEOUT_EN defined: timeout counter present, behaviour as above.
- ETC_ARB_TIMEOUT_EN undefined: no counter. BUSY waits indefinitely for eng_done. eng_abort and res_timeout tied 0. TIMEOUT_CYC is unused.

## Test plan
- Reset: hold reset_n=0, drive req=2'b11 -> all outputs 0. Release reset, req=2'b11 -> grant=2'b01 one cycle after release, eng_start pulse 1 cycle.
- Single lane: req=2'b10, eng_done with eng_speed=14'd60 five cycles after eng_start -> res_valid one cycle later, res_lane=1, res_speed=60, res_timeout=0, grant released the following cycle.
- Round-robin: req=2'b11 held, 4 transactions -> grant sequence 01,10,01,10.
- Timeout (macro on, TIMEOUT_CYC=16): no eng_done -> exactly 16 BUSY cycles, then res_valid=1, res_timeout=1, res_speed=0, eng_abort pulse. Same stimulus with macro off -> busy stays 1 and no res_valid.
- Boundary: eng_done on the final BUSY cycle (15th counter cycle) with eng_speed=14'd99 -> res_timeout=0, res_speed=99. eng_done in IDLE -> no res_valid.
- Mid-op reset: assert reset_n=0 during BUSY -> grant=0, busy=0 asynchronously. After release with req=2'b11 -> lane 0 granted first.
